ct_f_spsram_256x100_ctrl: RTL

Request/response front-end for the 256x100 single-port SRAM wrapper. It accepts read and lane-masked write requests on a valid/ready port and drives the SRAM's active-low pins, with `CEN`, `GWEN` and `WEN` decoded per 25-bit lane. Read data is captured into a small response FIFO so consumers can apply backpressure. An optional post-reset sweep zeroes the whole array.

---
 rtl/ct_f_spsram_256x100_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ct_f_spsram_256x100_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ct_f_spsram_256x100_ctrl                                          |
// | Brief  : Valid/ready request front-end for a 256x100 single-port SRAM.     |
// |          Reads land in a small response FIFO guarded by a credit scheme;   |
// |          writes are lane-masked in 25-bit lanes.                           |
// |          Optional macro CT_SPSRAM_CTRL_INIT_EN enables a post-reset sweep  |
// |          that zeroes all 256 entries before requests are accepted.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ct_f_spsram_256x100_ctrl #(
  parameter int RSP_DEPTH = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_wr,
  input  logic [7:0]   req_addr,
  input  logic [99:0]  req_wdata,
  input  logic [3:0]   req_wmask,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [99:0]  rsp_rdata,
  output logic         init_done,
  output logic [7:0]   sram_a,
  output logic         sram_cen,
  output logic         sram_gwen,
  output logic [99:0]  sram_wen,
  output logic [99:0]  sram_d,
  input  logic [99:0]  sram_q
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0]   C_DEPTH = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(RSP_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_inflight;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [99:0]   r_mem [RSP_DEPTH];

  logic          w_run;
  logic [CW:0]   w_used;
  logic          w_acc;
  logic          w_rd_acc;
  logic          w_push;
  logic          w_pop;

`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam state_t C_RST_STATE = ST_INIT;
  logic [7:0] r_icnt;

  // Sweep address counter; only advances while the array is being zeroed
  always_ff @(posedge CLK) begin
    if (RST || (r_state != ST_INIT)) r_icnt <= 8'd0;
    else                             r_icnt <= r_icnt + 8'd1;
  end
`else
  localparam state_t C_RST_STATE = ST_RUN;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= C_RST_STATE;
    else     r_state <= w_state_nxt;
  end

  // Outstanding reads (queued + in flight) must never exceed the FIFO size,
  // so a read can always be captured the cycle its data appears.
  assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_run    = (r_state == ST_RUN) && !RST;
  assign req_rdy  = w_run && (w_used < C_DEPTH);
  assign w_acc    = req_vld && req_rdy;
  assign w_rd_acc = w_acc && !req_wr;
  assign init_done = w_run;

  // Next-state and SRAM pin decode; pins idle unless sweeping or accepting
  always_comb begin
    w_state_nxt = r_state;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = 8'd0;
    sram_d      = '0;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    if (r_state == ST_INIT) begin
      if (!RST) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = r_icnt;
      end
      if (r_icnt == 8'hFF) w_state_nxt = ST_RUN;
    end
`endif
    if (w_acc) begin
      sram_a = req_addr;
      if (req_wr) begin
        // An all-zero mask is still accepted but never touches the array
        sram_cen  = (req_wmask == 4'd0);
        sram_gwen = 1'b0;
        sram_d    = req_wdata;
        for (int k = 0; k < 4; k++) begin
          sram_wen[25*k +: 25] = {25{~req_wmask[k]}};
        end
      end else begin
        sram_cen = 1'b0;
      end
    end
  end

  assign w_push = r_inflight;
  assign w_pop  = (r_count != '0) && rsp_rdy;

  // Read-in-flight flag and FIFO pointers/occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_rd_acc;
      if (w_push) r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage captures SRAM output the cycle after a read access
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= sram_q;
  end

  assign rsp_vld   = (r_count != '0);
  assign rsp_rdata = rsp_vld ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire
